// File: rtl/lm32_wb_arbiter_if.sv
// Wishbone B3 bundle for the arbiter; NUM_PORTS lanes packed side by side (lane k at k*width).
// The master modport drives requests and receives responses; the slave modport is the reverse.
interface lm32_wb_arbiter_if #(
  parameter int unsigned NUM_PORTS = 1,
  parameter int unsigned ADR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH = 32
);
  localparam int unsigned SelW = DAT_WIDTH / 8;

  logic [NUM_PORTS*ADR_WIDTH-1:0] adr;
  logic [NUM_PORTS*DAT_WIDTH-1:0] dat_w;
  logic [NUM_PORTS*SelW-1:0]      sel;
  logic [NUM_PORTS-1:0]           we;
  logic [NUM_PORTS*3-1:0]         cti;
  logic [NUM_PORTS*2-1:0]         bte;
  logic [NUM_PORTS-1:0]           lock;
  logic [NUM_PORTS-1:0]           cyc;
  logic [NUM_PORTS-1:0]           stb;
  logic [DAT_WIDTH-1:0]           dat_r;
  logic [NUM_PORTS-1:0]           ack;
  logic [NUM_PORTS-1:0]           err;
  logic [NUM_PORTS-1:0]           rty;

  modport master (
    output adr, dat_w, sel, we, cti, bte, lock, cyc, stb,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cti, bte, lock, cyc, stb,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/lm32_wb_arbiter.sv
// N-master to 1-slave Wishbone B3 round-robin arbiter with whole-cycle and lock grant hold.
// Optional bus watchdog enabled by defining LM32_WB_ARB_TIMEOUT_EN.
module lm32_wb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADR_WIDTH      = 32,
  parameter int unsigned DAT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  lm32_wb_arbiter_if.slave       m_bus,
  lm32_wb_arbiter_if.master      s_bus,
  output logic [NUM_MASTERS-1:0] grant_o
);
  localparam int unsigned IdxW = $clog2(NUM_MASTERS);
  localparam int unsigned SelW = DAT_WIDTH / 8;
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IdxW-1:0]        gidx_q, rr_q, pick_idx;
  logic [IdxW:0]          cand;
  logic                   found;
  logic                   timeout;

  logic [ADR_WIDTH-1:0] adr_mux;
  logic [DAT_WIDTH-1:0] dat_mux;
  logic [SelW-1:0]      sel_mux;
  logic [2:0]           cti_mux;
  logic [1:0]           bte_mux;
  logic                 we_mux, lock_mux, cyc_mux, stb_mux;

  // First requester at or after rr_q, wrapping round.
  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, rr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NUM_MASTERS)) cand = cand - (IdxW+1)'(NUM_MASTERS);
      if (!found && m_bus.cyc[cand[IdxW-1:0]]) begin
        found    = 1'b1;
        pick_idx = cand[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q <= NUM_MASTERS'(1) << pick_idx;
            gidx_q  <= pick_idx;
            state_q <= StOwned;
          end
        end
        StOwned: begin
          if (!(m_bus.cyc[gidx_q] || m_bus.lock[gidx_q])) begin
            grant_q <= '0;
            state_q <= StIdle;
            rr_q    <= (gidx_q == IdxW'(NUM_MASTERS - 1)) ? '0 : gidx_q + IdxW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // grant_q is zero when idle, so every slave-side output collapses to zero.
  always_comb begin
    adr_mux  = '0;
    dat_mux  = '0;
    sel_mux  = '0;
    cti_mux  = '0;
    bte_mux  = '0;
    we_mux   = 1'b0;
    lock_mux = 1'b0;
    cyc_mux  = 1'b0;
    stb_mux  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        adr_mux  = adr_mux | m_bus.adr[k*ADR_WIDTH +: ADR_WIDTH];
        dat_mux  = dat_mux | m_bus.dat_w[k*DAT_WIDTH +: DAT_WIDTH];
        sel_mux  = sel_mux | m_bus.sel[k*SelW +: SelW];
        cti_mux  = cti_mux | m_bus.cti[k*3 +: 3];
        bte_mux  = bte_mux | m_bus.bte[k*2 +: 2];
        we_mux   = we_mux | m_bus.we[k];
        lock_mux = lock_mux | m_bus.lock[k];
        cyc_mux  = cyc_mux | m_bus.cyc[k];
        stb_mux  = stb_mux | m_bus.stb[k];
      end
    end
  end

`ifdef LM32_WB_ARB_TIMEOUT_EN
  logic [15:0] wd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
    end else if (timeout || !stb_mux || s_bus.ack[0] || s_bus.err[0] || s_bus.rty[0]) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign timeout = (wd_q == TimeoutLimit);
`else
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^TimeoutLimit;
  assign timeout = 1'b0;
`endif

  assign s_bus.adr   = adr_mux;
  assign s_bus.dat_w = dat_mux;
  assign s_bus.sel   = sel_mux;
  assign s_bus.we    = we_mux;
  assign s_bus.cti   = cti_mux;
  assign s_bus.bte   = bte_mux;
  assign s_bus.lock  = lock_mux;
  assign s_bus.cyc   = cyc_mux & ~timeout;
  assign s_bus.stb   = stb_mux & ~timeout;

  assign m_bus.dat_r = s_bus.dat_r;
  assign m_bus.ack   = grant_q & {NUM_MASTERS{s_bus.ack[0]}};
  assign m_bus.err   = grant_q & {NUM_MASTERS{s_bus.err[0] | timeout}};
  assign m_bus.rty   = grant_q & {NUM_MASTERS{s_bus.rty[0]}};

  assign grant_o = grant_q;
endmodule

// File: tb/tb_lm32_wb_arbiter.sv
// Directed bench for lm32_wb_arbiter with three masters: vector table plus burst and stall sequences.
module tb_lm32_wb_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NV = 23;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] grant;
  int           tests = 0;
  int           failed = 0;

  lm32_wb_arbiter_if #(.NUM_PORTS(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW)) mbus ();
  lm32_wb_arbiter_if #(.NUM_PORTS(1), .ADR_WIDTH(AW), .DAT_WIDTH(DW)) sbus ();

  lm32_wb_arbiter #(
    .NUM_MASTERS   (N),
    .ADR_WIDTH     (AW),
    .DAT_WIDTH     (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .m_bus  (mbus),
    .s_bus  (sbus),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [2:0] cyc;
    logic [2:0] lock;
    logic       ack;
    logic       err;
    logic [2:0] e_grant;
    logic       e_scyc;
    logic [2:0] e_ack;
    logic [2:0] e_err;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [2:0] c, input logic [2:0] l,
                              input logic a, input logic e, input logic [2:0] eg,
                              input logic es, input logic [2:0] ea, input logic [2:0] ee);
    vec_t v;
    v = '{r, c, l, a, e, eg, es, ea, ee};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, leave time for combinational outputs to settle.
  task automatic step(input logic r, input logic [2:0] c, input logic [2:0] l,
                      input logic a, input logic e);
    rst       = r;
    mbus.cyc  = c;
    mbus.stb  = c;
    mbus.lock = l;
    sbus.ack  = a;
    sbus.err  = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    mbus.adr   = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    mbus.dat_w = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    mbus.sel   = 12'hFFF;
    mbus.we    = 3'b000;
    mbus.cti   = '0;
    mbus.bte   = '0;
    mbus.lock  = '0;
    mbus.cyc   = '0;
    mbus.stb   = '0;
    sbus.dat_r = 32'hDEAD_BEEF;
    sbus.ack   = 1'b0;
    sbus.err   = 1'b0;
    sbus.rty   = 1'b0;

    //                rst cyc     lock    ack   err   grant   scyc  m_ack   m_err
    vecs[0]  = mk(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[1]  = mk(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[2]  = mk(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 3'b000);
    vecs[3]  = mk(1'b0, 3'b110, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[4]  = mk(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000);
    vecs[5]  = mk(1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[6]  = mk(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b100, 1'b1, 3'b100, 3'b000);
    vecs[7]  = mk(1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[8]  = mk(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 3'b000);
    vecs[9]  = mk(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    // M1 locked: keeps the grant across its own idle gap while M0 waits.
    vecs[10] = mk(1'b0, 3'b011, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000);
    vecs[11] = mk(1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
    vecs[12] = mk(1'b0, 3'b011, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000);
    vecs[13] = mk(1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[14] = mk(1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000);
    vecs[15] = mk(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[16] = mk(1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 3'b000);
    vecs[17] = mk(1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b1, 3'b000, 3'b010);
    vecs[18] = mk(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[19] = mk(1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000);
    vecs[20] = mk(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);
    vecs[21] = mk(1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000);
    vecs[22] = mk(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].cyc, vecs[i].lock, vecs[i].ack, vecs[i].err);
      check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
      check($sformatf("v%0d s_cyc", i), 32'(sbus.cyc), 32'(vecs[i].e_scyc));
      check($sformatf("v%0d m_ack", i), 32'(mbus.ack), 32'(vecs[i].e_ack));
      check($sformatf("v%0d m_err", i), 32'(mbus.err), 32'(vecs[i].e_err));
      check($sformatf("v%0d m_rty", i), 32'(mbus.rty), 32'h0);
      check($sformatf("v%0d m_dat", i), mbus.dat_r, 32'hDEAD_BEEF);
    end

    // Burst hold: M0 incrementing burst with M1 waiting.
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    mbus.cti = {3'b000, 3'b000, 3'b010};
    step(1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    check("burst grant", 32'(grant), 32'h1);
    check("burst s_adr", sbus.adr, 32'h0000_1000);
    check("burst s_cti", 32'(sbus.cti), 32'h2);
    for (int b = 0; b < 4; b++) begin
      mbus.adr[31:0] = 32'h0000_1000 + 32'(4 * b);
      mbus.cti[2:0]  = (b == 3) ? 3'b111 : 3'b010;
      step(1'b0, 3'b011, 3'b000, 1'b1, 1'b0);
      check($sformatf("beat%0d grant", b), 32'(grant), 32'h1);
      check($sformatf("beat%0d m_ack", b), 32'(mbus.ack), 32'h1);
      check($sformatf("beat%0d s_adr", b), sbus.adr, 32'h0000_1000 + 32'(4 * b));
    end
    step(1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    check("burst release gap", 32'(grant), 32'h0);
    step(1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    check("burst next owner", 32'(grant), 32'h2);
    check("burst next s_adr", sbus.adr, 32'h0000_2000);
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    check("burst idle", 32'(grant), 32'h0);

    // Stalled slave: watchdog fires every 9th cycle when built in, never otherwise.
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      logic to_exp;
`ifdef LM32_WB_ARB_TIMEOUT_EN
      to_exp = (k % 9 == 8);
`else
      to_exp = 1'b0;
`endif
      step(1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
      check($sformatf("stall%0d grant", k), 32'(grant), 32'h1);
      check($sformatf("stall%0d m_err", k), 32'(mbus.err), to_exp ? 32'h1 : 32'h0);
      check($sformatf("stall%0d s_cyc", k), 32'(sbus.cyc), to_exp ? 32'h0 : 32'h1);
    end
    step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    check("stall release", 32'(grant), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
